// File: rtl/multi_cycle_control.sv
// Control unit for a five-state multi-cycle processor: sequences fetch, decode,
// execute, memory and writeback, and counts retired instructions.
module multi_cycle_control #(
    parameter int COUNT_W = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [15:0]        Instr,
    input  logic               MemReady,
    input  logic               Zero,
    output logic               MemReq,
    output logic               MemWe,
    output logic               IrWrite,
    output logic               PcWrite,
    output logic [1:0]         PcSrc,
    output logic [1:0]         AluOp,
    output logic               AluSrcB,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               MemToReg,
    output logic [3:0]         Func,
    output logic               Illegal,
    output logic [COUNT_W-1:0] RetireCount,
    output logic [2:0]         State
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_SW    = 4'b1100;
    localparam logic [3:0] OP_BEQ   = 4'b0010;
    localparam logic [3:0] OP_JUMP  = 4'b0011;

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_ir;
    logic [COUNT_W-1:0] r_retire_cnt;

    logic       w_is_r, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_jump, w_is_legal;
    logic       w_mem_req, w_mem_we, w_ir_write, w_pc_write, w_alu_src_b;
    logic       w_reg_dst, w_reg_write, w_mem_to_reg, w_illegal, w_retire;
    logic [1:0] w_pc_src, w_alu_op;
    logic       w_unused_ir;

    assign w_is_r      = (r_ir[15:12] == OP_RTYPE);
    assign w_is_addi   = (r_ir[15:12] == OP_ADDI);
    assign w_is_lw     = (r_ir[15:12] == OP_LW);
    assign w_is_sw     = (r_ir[15:12] == OP_SW);
    assign w_is_beq    = (r_ir[15:12] == OP_BEQ);
    assign w_is_jump   = (r_ir[15:12] == OP_JUMP);
    assign w_is_legal  = w_is_r | w_is_addi | w_is_lw | w_is_sw | w_is_beq | w_is_jump;
    // Register-field bits belong to the datapath; control only needs opcode and function.
    assign w_unused_ir = ^r_ir[11:4];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_ir <= 16'h0000;
        end else if (w_ir_write) begin
            r_ir <= Instr;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_retire_cnt <= '0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + COUNT_W'(1);
        end
    end

    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 2'b00;
        w_alu_op     = 2'b00;
        w_alu_src_b  = 1'b0;
        w_reg_dst    = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_illegal    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (MemReady) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!w_is_legal) begin
                    w_illegal = 1'b1;
                    w_next    = S_FETCH;
                end else if (w_is_jump) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = 2'b10;
                    w_retire   = 1'b1;
                    w_next     = S_FETCH;
                end else begin
                    w_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (w_is_r) begin
                    w_alu_op = 2'b10;
                    w_next   = S_WRITEBACK;
                end else if (w_is_addi) begin
                    w_alu_src_b = 1'b1;
                    w_next      = S_WRITEBACK;
                end else if (w_is_lw || w_is_sw) begin
                    w_alu_src_b = 1'b1;
                    w_next      = S_MEM;
                end else if (w_is_beq) begin
                    w_alu_op   = 2'b01;
                    w_pc_write = Zero;
                    w_pc_src   = 2'b01;
                    w_retire   = 1'b1;
                    w_next     = S_FETCH;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEM: begin
                w_mem_req   = 1'b1;
                w_mem_we    = w_is_sw;
                w_alu_src_b = 1'b1;
                if (MemReady) begin
                    if (w_is_sw) begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = w_is_r;
                w_mem_to_reg = w_is_lw;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held, without waiting for a clock.
    assign MemReq      = Reset & w_mem_req;
    assign MemWe       = Reset & w_mem_we;
    assign IrWrite     = Reset & w_ir_write;
    assign PcWrite     = Reset & w_pc_write;
    assign PcSrc       = Reset ? w_pc_src : 2'b00;
    assign AluOp       = Reset ? w_alu_op : 2'b00;
    assign AluSrcB     = Reset & w_alu_src_b;
    assign RegDst      = Reset & w_reg_dst;
    assign RegWrite    = Reset & w_reg_write;
    assign MemToReg    = Reset & w_mem_to_reg;
    assign Illegal     = Reset & w_illegal;
    assign Func        = r_ir[3:0];
    assign RetireCount = r_retire_cnt;
    assign State       = r_state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: walks each instruction class through
// its states and checks control outputs, cycle counts and the retire counter.
module tb_multi_cycle_control;

    localparam int CW = 8;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [15:0]   Instr;
    logic          MemReady;
    logic          Zero;
    logic          MemReq, MemWe, IrWrite, PcWrite, AluSrcB, RegDst, RegWrite, MemToReg, Illegal;
    logic [1:0]    PcSrc, AluOp;
    logic [3:0]    Func;
    logic [CW-1:0] RetireCount;
    logic [2:0]    State;

    int n_chk = 0;
    int n_err = 0;
    int cyc;
    int total;

    multi_cycle_control #(.COUNT_W(CW)) dut (
        .Clock(Clock), .Reset(Reset), .Instr(Instr), .MemReady(MemReady), .Zero(Zero),
        .MemReq(MemReq), .MemWe(MemWe), .IrWrite(IrWrite), .PcWrite(PcWrite), .PcSrc(PcSrc),
        .AluOp(AluOp), .AluSrcB(AluSrcB), .RegDst(RegDst), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .Func(Func), .Illegal(Illegal), .RetireCount(RetireCount),
        .State(State)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    // Starts in FETCH; counts edges until the FSM is back in FETCH (bounded).
    task automatic run_instr(input logic [15:0] ins, input logic z, output int n);
        Instr    = ins;
        Zero     = z;
        MemReady = 1'b1;
        n        = 0;
        do begin
            tick();
            n++;
        end while (State != 3'd0 && n < 20);
    endtask

    initial begin
        Reset = 1'b0; Instr = 16'h0000; MemReady = 1'b1; Zero = 1'b0;
        #2;
        check("rst_state", 32'(State), 32'd0);
        check("rst_memreq", 32'(MemReq), 32'd0);
        check("rst_irwrite", 32'(IrWrite), 32'd0);
        check("rst_pcwrite", 32'(PcWrite), 32'd0);
        check("rst_retire", 32'(RetireCount), 32'd0);
        check("rst_func", 32'(Func), 32'd0);
        MemReady = 1'b0;
        #6 Reset = 1'b1;
        #1;
        check("fetch_memreq", 32'(MemReq), 32'd1);
        check("fetch_hold_irw", 32'(IrWrite), 32'd0);
        tick();
        check("fetch_hold_state", 32'(State), 32'd0);

        // R-type 0x0A3F
        Instr = 16'h0A3F; MemReady = 1'b1;
        #1;
        check("r_irwrite", 32'(IrWrite), 32'd1);
        check("r_pcwrite", 32'(PcWrite), 32'd1);
        check("r_pcsrc", 32'(PcSrc), 32'd0);
        tick();
        Instr = 16'h0000;
        #1;
        check("r_decode", 32'(State), 32'd1);
        check("r_func", 32'(Func), 32'hF);
        tick();
        check("r_execute", 32'(State), 32'd2);
        check("r_aluop", 32'(AluOp), 32'd2);
        check("r_alusrcb", 32'(AluSrcB), 32'd0);
        check("r_func_hold", 32'(Func), 32'hF);
        tick();
        check("r_wb", 32'(State), 32'd4);
        check("r_regwrite", 32'(RegWrite), 32'd1);
        check("r_regdst", 32'(RegDst), 32'd1);
        check("r_memtoreg", 32'(MemToReg), 32'd0);
        tick();
        check("r_back_fetch", 32'(State), 32'd0);
        check("r_regwrite_off", 32'(RegWrite), 32'd0);
        check("r_retire", 32'(RetireCount), 32'd1);

        // LW 0x8125 with three MEM wait states
        total = 0;
        Instr = 16'h8125; MemReady = 1'b1;
        tick(); total++;
        tick(); total++;
        check("lw_execute", 32'(State), 32'd2);
        check("lw_alusrcb", 32'(AluSrcB), 32'd1);
        check("lw_aluop", 32'(AluOp), 32'd0);
        MemReady = 1'b0;
        tick(); total++;
        for (int i = 0; i < 3; i++) begin
            check("lw_mem_state", 32'(State), 32'd3);
            check("lw_mem_req", 32'(MemReq), 32'd1);
            check("lw_mem_we", 32'(MemWe), 32'd0);
            tick(); total++;
        end
        MemReady = 1'b1;
        #1;
        check("lw_mem_last", 32'(State), 32'd3);
        check("lw_mem_req_last", 32'(MemReq), 32'd1);
        tick(); total++;
        check("lw_wb", 32'(State), 32'd4);
        check("lw_memtoreg", 32'(MemToReg), 32'd1);
        check("lw_regdst", 32'(RegDst), 32'd0);
        check("lw_regwrite", 32'(RegWrite), 32'd1);
        tick(); total++;
        check("lw_cycles", 32'(total), 32'd8);
        check("lw_retire", 32'(RetireCount), 32'd2);

        run_instr(16'h4123, 1'b0, cyc);
        check("addi_cycles", 32'(cyc), 32'd4);
        run_instr(16'hC000, 1'b0, cyc);
        check("sw_cycles", 32'(cyc), 32'd4);
        check("addi_sw_retire", 32'(RetireCount), 32'd4);

        // BEQ taken, Zero already high in DECODE must not write PC
        Instr = 16'h2000; Zero = 1'b1; MemReady = 1'b1;
        tick();
        check("beq_dec_pcwrite", 32'(PcWrite), 32'd0);
        tick();
        check("beq1_aluop", 32'(AluOp), 32'd1);
        check("beq1_pcwrite", 32'(PcWrite), 32'd1);
        check("beq1_pcsrc", 32'(PcSrc), 32'd1);
        tick();
        check("beq1_fetch", 32'(State), 32'd0);
        check("beq1_retire", 32'(RetireCount), 32'd5);
        run_instr(16'h2000, 1'b0, cyc);
        check("beq0_cycles", 32'(cyc), 32'd3);
        check("beq0_retire", 32'(RetireCount), 32'd6);
        Zero = 1'b0;
        Instr = 16'h2000;
        tick(); tick();
        check("beq0_pcwrite", 32'(PcWrite), 32'd0);
        check("beq0_pcsrc", 32'(PcSrc), 32'd1);
        tick();
        check("beq0b_retire", 32'(RetireCount), 32'd7);

        // Illegal 0xF00E
        Instr = 16'hF00E;
        tick();
        check("ill_state", 32'(State), 32'd1);
        check("ill_flag", 32'(Illegal), 32'd1);
        check("ill_regwrite", 32'(RegWrite), 32'd0);
        tick();
        check("ill_fetch", 32'(State), 32'd0);
        check("ill_flag_off", 32'(Illegal), 32'd0);
        check("ill_retire", 32'(RetireCount), 32'd7);

        // JUMP
        Instr = 16'h3000;
        tick();
        check("jmp_pcwrite", 32'(PcWrite), 32'd1);
        check("jmp_pcsrc", 32'(PcSrc), 32'd2);
        tick();
        check("jmp_fetch", 32'(State), 32'd0);
        check("jmp_retire", 32'(RetireCount), 32'd8);

        // SW stalled in MEM, aborted by asynchronous reset
        Instr = 16'hC123;
        tick(); tick();
        MemReady = 1'b0;
        tick();
        check("swr_mem", 32'(State), 32'd3);
        check("swr_memwe", 32'(MemWe), 32'd1);
        #2 Reset = 1'b0;
        #1;
        check("swr_memreq", 32'(MemReq), 32'd0);
        check("swr_memwe_off", 32'(MemWe), 32'd0);
        check("swr_state", 32'(State), 32'd0);
        check("swr_retire", 32'(RetireCount), 32'd0);
        Reset = 1'b1;

        // Counter wrap over 2**CW jumps
        total = 0;
        for (int i = 0; i < 255; i++) begin
            run_instr(16'h3000, 1'b0, cyc);
            total += cyc;
        end
        check("wrap_allones", 32'(RetireCount), 32'd255);
        run_instr(16'h3000, 1'b0, cyc);
        total += cyc;
        check("wrap_zero", 32'(RetireCount), 32'd0);
        check("wrap_cycles", 32'(total), 32'd512);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
